i2c_slave: RTL and testbench

- I2C target (slave) that pairs with the team's I2C master on the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, then either receives up to 4 write bytes into a 32-bit register or returns up to 4 bytes from a 32-bit transmit word.
- SDA is open-drain (drive 0 or release); SCL is never driven (no clock stretching).

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_bus_sampler.sv | 59 +++++
 rtl/i2c_slave.sv | 268 ++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, byte/bit counts,
// bus line levels and a helper that picks a read byte out of the transmit word.
package i2c_pkg;

    // FSM states; numeric values are visible on the istate debug port
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WRITE     = 4'd3,
        ST_WACK      = 4'd4,
        ST_READ      = 4'd5,
        ST_RACK      = 4'd6,
        ST_WAIT_STOP = 4'd7
    } state_t;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned MAX_BYTES     = 4;

    // Bus levels seen on SDA during the acknowledge slot
    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    // Byte idx of a 32-bit word, byte 0 in [31:24]; idle-bus 8'hFF past the end
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = word[31:24];
            3'd1:    b = word[23:16];
            3'd2:    b = word[15:8];
            3'd3:    b = word[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronizes SCL/SDA into the clk domain and flags bus events.
//   clk, rst       system clock, asynchronous active-low reset
//   scl_in, sda_in raw bus pins
//   scl_rise/fall  one-clk SCL edge strobes
//   start_det      SDA fell while SCL high
//   stop_det       SDA rose while SCL high
//   sda            synchronized SDA, time-aligned with the strobes
// Pin-to-strobe latency is SYNC_STAGES+1 clocks. SYNC_STAGES must be >= 2.
module i2c_bus_sampler #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchronizer chain, history flop and registered event strobes.
    // Flops reset to 1 (idle bus) so no event fires when reset releases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda       <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist  <= scl_s;
            sda_hist  <= sda_s;
            scl_rise  <= scl_s & ~scl_hist;
            scl_fall  <= ~scl_s & scl_hist;
            start_det <= scl_s & scl_hist & sda_hist & ~sda_s;
            stop_det  <= scl_s & scl_hist & ~sda_hist & sda_s;
            sda       <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, up to 4-byte write into rx_data, up to
// 4-byte read from a tx_data snapshot. SDA is open-drain, SCL is never driven.
//   clk, rst   system clock (>= 8x SCL), asynchronous active-low reset
//   i2c_scl    bus clock (input only)
//   i2c_sda    bus data, driven low or released
//   tx_data    read payload, latched when a read address is ACKed
//   rx_data    write payload, first byte in [31:24]
//   rx_count   bytes stored by the last write transfer
//   rx_valid   one-clk pulse on STOP after a write that stored bytes
//   rd_req     one-clk pulse when tx_data is latched
//   busy       addressed and transfer in progress
//   istate     FSM state for debug
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic [2:0]  rx_count,
    output logic        rx_valid,
    output logic        rd_req,
    output logic        busy,
    output logic [3:0]  istate
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    state_t      state,     state_nxt;
    logic [3:0]  bit_cnt,   bit_cnt_nxt;
    logic [7:0]  shift,     shift_nxt;
    logic        rw,        rw_nxt;
    logic [2:0]  byte_idx,  byte_idx_nxt;
    logic [31:0] tx_word,   tx_word_nxt;
    logic        sda_oe,    sda_oe_nxt;
    logic        ack_phase, ack_phase_nxt;
    logic        ack_ok,    ack_ok_nxt;
    logic        wr_xfer,   wr_xfer_nxt;
    logic [31:0] rx_data_nxt;
    logic [2:0]  rx_count_nxt;
    logic        rx_valid_nxt;
    logic        rd_req_nxt;
    logic        busy_nxt;
    logic [7:0]  in_byte;
    logic [7:0]  cur_byte;

    i2c_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (i2c_scl),
        .sda_in    (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda_s)
    );

    // Open drain: the only level ever driven is the ACK (low) level
    assign i2c_sda = sda_oe ? ACK_LEVEL : 1'bz;
    assign istate  = state;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            rw        <= 1'b0;
            byte_idx  <= 3'd0;
            tx_word   <= 32'd0;
            sda_oe    <= 1'b0;
            ack_phase <= 1'b0;
            ack_ok    <= 1'b0;
            wr_xfer   <= 1'b0;
            rx_data   <= 32'd0;
            rx_count  <= 3'd0;
            rx_valid  <= 1'b0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            rw        <= rw_nxt;
            byte_idx  <= byte_idx_nxt;
            tx_word   <= tx_word_nxt;
            sda_oe    <= sda_oe_nxt;
            ack_phase <= ack_phase_nxt;
            ack_ok    <= ack_ok_nxt;
            wr_xfer   <= wr_xfer_nxt;
            rx_data   <= rx_data_nxt;
            rx_count  <= rx_count_nxt;
            rx_valid  <= rx_valid_nxt;
            rd_req    <= rd_req_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and datapath logic; STOP beats START beats SCL edges
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        rw_nxt        = rw;
        byte_idx_nxt  = byte_idx;
        tx_word_nxt   = tx_word;
        sda_oe_nxt    = sda_oe;
        ack_phase_nxt = ack_phase;
        ack_ok_nxt    = ack_ok;
        wr_xfer_nxt   = wr_xfer;
        rx_data_nxt   = rx_data;
        rx_count_nxt  = rx_count;
        busy_nxt      = busy;
        rx_valid_nxt  = 1'b0;
        rd_req_nxt    = 1'b0;
        in_byte       = {shift[6:0], sda_s};
        cur_byte      = word_byte(tx_word, byte_idx);

        if (stop_det) begin
            state_nxt     = ST_IDLE;
            sda_oe_nxt    = 1'b0;
            ack_phase_nxt = 1'b0;
            busy_nxt      = 1'b0;
            wr_xfer_nxt   = 1'b0;
            rx_valid_nxt  = wr_xfer && (rx_count != 3'd0);
        end else if (start_det) begin
            state_nxt     = ST_ADDR;
            bit_cnt_nxt   = 4'd0;
            sda_oe_nxt    = 1'b0;
            ack_phase_nxt = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = in_byte;
                        if (bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                            bit_cnt_nxt = 4'd0;
                            // General call (0x00) never matches
                            if (in_byte[7:1] == SLAVE_ADDR && in_byte[7:1] != 7'd0) begin
                                state_nxt     = ST_ADDR_ACK;
                                rw_nxt        = in_byte[0];
                                busy_nxt      = 1'b1;
                                ack_phase_nxt = 1'b0;
                                wr_xfer_nxt   = ~in_byte[0];
                                if (!in_byte[0]) begin
                                    rx_data_nxt  = 32'd0;
                                    rx_count_nxt = 3'd0;
                                end
                            end else begin
                                state_nxt   = ST_WAIT_STOP;
                                busy_nxt    = 1'b0;
                                wr_xfer_nxt = 1'b0;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end

                // First fall: pull SDA low. Second fall: end of the ACK clock.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_nxt    = 1'b1;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            ack_phase_nxt = 1'b0;
                            if (!rw) begin
                                state_nxt   = ST_WRITE;
                                sda_oe_nxt  = 1'b0;
                                bit_cnt_nxt = 4'd0;
                            end else begin
                                // Snapshot payload and put its MSB on the bus now
                                state_nxt    = ST_READ;
                                tx_word_nxt  = tx_data;
                                rd_req_nxt   = 1'b1;
                                byte_idx_nxt = 3'd0;
                                sda_oe_nxt   = ~tx_data[31];
                                bit_cnt_nxt  = 4'd1;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_nxt = in_byte;
                        if (bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                            bit_cnt_nxt   = 4'd0;
                            state_nxt     = ST_WACK;
                            ack_phase_nxt = 1'b0;
                            if (rx_count < 3'(MAX_BYTES)) begin
                                ack_ok_nxt   = 1'b1;
                                rx_count_nxt = rx_count + 3'd1;
                                case (rx_count[1:0])
                                    2'd0:    rx_data_nxt[31:24] = in_byte;
                                    2'd1:    rx_data_nxt[23:16] = in_byte;
                                    2'd2:    rx_data_nxt[15:8]  = in_byte;
                                    default: rx_data_nxt[7:0]   = in_byte;
                                endcase
                            end else begin
                                ack_ok_nxt = 1'b0;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end

                // ACK (or NACK by staying released) for one SCL clock
                ST_WACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_nxt    = ack_ok;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt    = 1'b0;
                            ack_phase_nxt = 1'b0;
                            state_nxt     = ack_ok ? ST_WRITE : ST_WAIT_STOP;
                        end
                    end
                end

                // bit_cnt counts bits already placed on the bus
                ST_READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'(BITS_PER_BYTE)) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = ST_RACK;
                        end else begin
                            sda_oe_nxt  = ~cur_byte[3'(BITS_PER_BYTE - 1) - bit_cnt[2:0]];
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end

                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK_LEVEL) begin
                            state_nxt = ST_WAIT_STOP;
                        end else begin
                            state_nxt   = ST_READ;
                            bit_cnt_nxt = 4'd0;
                            if (byte_idx < 3'(MAX_BYTES)) begin
                                byte_idx_nxt = byte_idx + 3'd1;
                            end
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench for i2c_slave: a bit-banged I2C master drives
// SCL/SDA and results are compared against a byte-level model of the target.
module tb_i2c_slave;

    localparam int unsigned Q        = 4;
    localparam logic [6:0]  OWN_ADDR = 7'h50;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl;
    logic        m_sda;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic [2:0]  rx_count;
    logic        rx_valid;
    logic        rd_req;
    logic        busy;
    logic [3:0]  istate;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_slave #(
        .SLAVE_ADDR  (OWN_ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (m_scl),
        .i2c_sda  (sda_bus),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_count (rx_count),
        .rx_valid (rx_valid),
        .rd_req   (rd_req),
        .busy     (busy),
        .istate   (istate)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rxv   = 0;
    int n_rdreq = 0;
    int n_busy  = 0;
    int n_low   = 0;

    // Model state: contents expected in rx_data/rx_count
    logic [31:0] m_rx_data  = 32'd0;
    logic [2:0]  m_rx_count = 3'd0;
    logic [7:0]  wbuf [8];

    // Event monitors; sampled on the falling clock edge
    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_rxv++;
        if (rd_req === 1'b1) n_rdreq++;
        if (busy === 1'b1) n_busy++;
        if (m_sda === 1'b1 && sda_bus === 1'b0) n_low++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
        tick(4);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = (b === 1'b0);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(!ack);
    endtask

    // Byte i of a read: word bytes MSB first, then idle-bus 0xFF
    function automatic logic [7:0] exp_rd(input logic [31:0] w, input int i);
        if (i >= 4) return 8'hFF;
        return 8'(w >> (24 - 8 * i));
    endfunction

    // START, address byte, n data bytes from wbuf, STOP
    task automatic write_xfer(input logic [6:0] addr, input int n);
        logic ack;
        logic hit;
        int   rxv0, low0, busy0;
        hit   = (addr == OWN_ADDR);
        rxv0  = n_rxv;
        low0  = n_low;
        busy0 = n_busy;
        bus_start();
        put_byte({addr, 1'b0}, ack);
        check("addr_ack", 32'(ack), 32'(hit));
        if (hit) begin
            m_rx_data  = 32'd0;
            m_rx_count = 3'd0;
            for (int i = 0; i < n; i++) begin
                put_byte(wbuf[i], ack);
                check("data_ack", 32'(ack), (i < 4) ? 32'd1 : 32'd0);
                if (i < 4) begin
                    m_rx_data  = m_rx_data | (32'(wbuf[i]) << (24 - 8 * i));
                    m_rx_count = m_rx_count + 3'd1;
                end
            end
        end else begin
            check("nomatch_state", 32'(istate), 32'd7);
        end
        bus_stop();
        check("rx_valid_pulses", 32'(n_rxv - rxv0), (hit && n > 0) ? 32'd1 : 32'd0);
        check("rx_data", rx_data, m_rx_data);
        check("rx_count", 32'(rx_count), 32'(m_rx_count));
        check("idle_after_stop", 32'(istate), 32'd0);
        check("busy_after_stop", 32'(busy), 32'd0);
        if (!hit) begin
            check("nomatch_sda_low", 32'(n_low - low0), 32'd0);
            check("nomatch_busy", 32'(n_busy - busy0), 32'd0);
        end
    endtask

    // After a START: read address, n bytes (last one NACKed); caller sends STOP
    task automatic read_body(input int n);
        logic        ack;
        logic [7:0]  d;
        logic [31:0] snap;
        int          rdq0;
        snap = tx_data;
        rdq0 = n_rdreq;
        put_byte({OWN_ADDR, 1'b1}, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        // Payload must have been captured already; changes now are ignored
        tx_data = $urandom();
        check("rd_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            get_byte(d, i < n - 1);
            check("rd_byte", 32'(d), 32'(exp_rd(snap, i)));
        end
        check("rd_req_pulses", 32'(n_rdreq - rdq0), 32'd1);
        check("rd_wait_stop", 32'(istate), 32'd7);
    endtask

    initial begin
        logic ack;
        int   rxv0, low0, n;
        logic [6:0] a;

        rst     = 1'b0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 32'd0;
        tick(3);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_istate", 32'(istate), 32'd0);
        check("rst_sda", 32'(sda_bus), 32'd1);
        rst = 1'b1;
        tick(4);

        // 4-byte write
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
        write_xfer(OWN_ADDR, 4);
        check("deadbeef", rx_data, 32'hDEADBEEF);

        // Foreign address and general call
        write_xfer(7'h51, 0);
        write_xfer(7'h00, 2);

        // Write address, repeated START, 4-byte read
        tx_data = 32'h12345678;
        rxv0 = n_rxv;
        bus_start();
        put_byte({OWN_ADDR, 1'b0}, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        m_rx_data  = 32'd0;
        m_rx_count = 3'd0;
        bus_start();
        read_body(4);
        bus_stop();
        check("rd_idle", 32'(istate), 32'd0);
        check("rd_busy_low", 32'(busy), 32'd0);
        check("rd_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);

        // 5-byte write, 5th NACKed
        for (int i = 0; i < 5; i++) wbuf[i] = 8'(i + 1);
        write_xfer(OWN_ADDR, 5);
        check("overflow_data", rx_data, 32'h01020304);

        // Randomized writes
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom());
            a = OWN_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == OWN_ADDR) a = 7'h51;
            end
            write_xfer(a, n);
        end

        // Randomized reads, including past the end of the word
        for (int k = 0; k < 4; k++) begin
            tx_data = $urandom();
            n = $urandom_range(1, 6);
            bus_start();
            read_body(n);
            bus_stop();
            check("rnd_rd_idle", 32'(istate), 32'd0);
        end

        // Reset while the target drives a 0 data bit
        tx_data = 32'h12345678;
        bus_start();
        put_byte({OWN_ADDR, 1'b1}, ack);
        check("rstrd_addr_ack", 32'(ack), 32'd1);
        tick(2);
        check("rstrd_driving0", 32'(sda_bus), 32'd0);
        rst = 1'b0;
        #1;
        check("rstrd_sda_released", 32'(sda_bus), 32'd1);
        check("rstrd_istate", 32'(istate), 32'd0);
        check("rstrd_busy", 32'(busy), 32'd0);
        check("rstrd_rx_data", rx_data, 32'd0);
        check("rstrd_rx_count", 32'(rx_count), 32'd0);
        m_rx_data  = 32'd0;
        m_rx_count = 3'd0;
        tick(2);
        rst = 1'b1;
        tick(4);
        bus_stop();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom());
        write_xfer(OWN_ADDR, 4);

        // STOP after three address bits
        rxv0 = n_rxv;
        low0 = n_low;
        bus_start();
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        bus_stop();
        check("glitch_idle", 32'(istate), 32'd0);
        check("glitch_no_ack", 32'(n_low - low0), 32'd0);
        check("glitch_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
        check("glitch_rx_count", 32'(rx_count), 32'(m_rx_count));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
